// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter that time-shares one bitwise gate unit between NREQ requesters
// and returns each result, tagged with the winner's index, over a valid/ready channel.
`timescale 1ns/1ps
module gate_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [3*NREQ-1:0]        op,
  input  logic [WIDTH*NREQ-1:0]    a,
  input  logic [WIDTH*NREQ-1:0]    b,
  output logic [NREQ-1:0]          gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = IDW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  state_e            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    id_q;
  op_e               op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [NREQ-1:0]   gnt_q;
  logic              rsp_valid_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic [IDW-1:0]    rsp_id_q;
  logic              rsp_err_q;

  logic              win_found_d;
  logic [IDW-1:0]    win_idx_d;
  logic [IDW-1:0]    ptr_d;
  logic [CW-1:0]     cand;
  logic [2:0]        win_op_d;
  logic [WIDTH-1:0]  win_a_d;
  logic [WIDTH-1:0]  win_b_d;
  logic [WIDTH-1:0]  gate_data_d;
  logic              gate_err_d;

  // Walk the requesters starting at ptr_q, wrapping modulo NREQ; first hit wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!win_found_d && req[cand[IDW-1:0]]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand[IDW-1:0];
      end
    end
  end

  assign ptr_d = (win_idx_d == IDW'(NREQ-1)) ? '0 : win_idx_d + IDW'(1);

  always_comb begin
    win_op_d = '0;
    win_a_d  = '0;
    win_b_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_d == IDW'(i)) begin
        win_op_d = op[3*i +: 3];
        win_a_d  = a[WIDTH*i +: WIDTH];
        win_b_d  = b[WIDTH*i +: WIDTH];
      end
    end
  end

  // The single shared gate unit, fed only from the operands latched at grant.
  always_comb begin
    gate_data_d = '0;
    gate_err_d  = 1'b0;
    case (op_q)
      OP_NOT:  gate_data_d = ~a_q;
      OP_AND:  gate_data_d = a_q & b_q;
      OP_OR:   gate_data_d = a_q | b_q;
      OP_NAND: gate_data_d = ~(a_q & b_q);
      OP_NOR:  gate_data_d = ~(a_q | b_q);
      OP_XOR:  gate_data_d = a_q ^ b_q;
      OP_XNOR: gate_data_d = ~(a_q ^ b_q);
      default: gate_err_d  = 1'b1;
    endcase
  end

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= OP_NOT;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            op_q    <= op_e'(win_op_d);
            a_q     <= win_a_d;
            b_q     <= win_b_d;
            id_q    <= win_idx_d;
            gnt_q   <= NREQ'(1) << win_idx_d;
            ptr_q   <= ptr_d;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          gnt_q       <= '0;
          rsp_data_q  <= gate_data_d;
          rsp_err_q   <= gate_err_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Bench for gate_unit_arbiter: directed vectors, hand-written corner sequences and a
// randomized run against a truth-table based transaction model.
`timescale 1ns/1ps
module tb_gate_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req;
  logic [3*NREQ-1:0]       op;
  logic [WIDTH*NREQ-1:0]   a;
  logic [WIDTH*NREQ-1:0]   b;
  logic [NREQ-1:0]         gnt;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WIDTH-1:0]        rsp_data;
  logic [1:0]              rsp_id;
  logic                    rsp_err;
  logic                    busy;

  int n_checks = 0;
  int n_errors = 0;

  gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  // Truth table per opcode, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8] = '{4'b0011, 4'b1000, 4'b1110, 4'b0111,
                         4'b0001, 4'b0110, 4'b1001, 4'b0000};

  function automatic logic [7:0] gate_ref(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic [3:0] row;
    row = tt[o];
    for (int i = 0; i < 8; i++) r[i] = row[{x[i], y[i]}];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    rsp_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    tick();
    check("rst_gnt",   32'(gnt), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_data",  32'(rsp_data), 0);
    check("rst_id",    32'(rsp_id), 0);
    check("rst_err",   32'(rsp_err), 0);
    check("rst_busy",  32'(busy), 0);
    rst_n = 1'b1;
  endtask

  task automatic serve(input vec_t v);
    req                   = '0;
    req[v.id]             = 1'b1;
    op                    = 12'($urandom);
    a                     = $urandom;
    b                     = $urandom;
    op[3*v.id +: 3]       = v.op;
    a[WIDTH*v.id +: WIDTH] = v.a;
    b[WIDTH*v.id +: WIDTH] = v.b;
    rsp_ready             = 1'b1;
    tick();
    check("vec_gnt",        32'(gnt), 32'(1) << v.id);
    check("vec_busy",       32'(busy), 1);
    check("vec_valid_exec", 32'(rsp_valid), 0);
    // Requester drops its request and scrambles operands once it sees gnt.
    req = '0;
    op  = 12'($urandom);
    a   = $urandom;
    b   = $urandom;
    tick();
    check("vec_gnt_off", 32'(gnt), 0);
    check("vec_valid",   32'(rsp_valid), 1);
    check("vec_data",    32'(rsp_data), 32'(v.exp_data));
    check("vec_id",      32'(rsp_id), 32'(v.id));
    check("vec_err",     32'(rsp_err), 32'(v.exp_err));
    tick();
    check("vec_valid_drop", 32'(rsp_valid), 0);
    check("vec_idle",       32'(busy), 0);
  endtask

  // Transaction-level reference model state.
  int         m_ptr;
  int         m_age;
  int         m_win;
  logic [3:0] m_gnt;
  logic       m_valid;
  logic       m_err;
  logic [7:0] m_data;
  logic [2:0] m_op;
  logic [7:0] m_a;
  logic [7:0] m_b;

  task automatic model_step();
    bit found;
    if (m_age < 0) begin
      m_gnt = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int w;
        w = (m_ptr + k) % NREQ;
        if (!found && req[w]) begin
          found = 1'b1;
          m_win = w;
        end
      end
      if (found) begin
        m_op  = op[3*m_win +: 3];
        m_a   = a[WIDTH*m_win +: WIDTH];
        m_b   = b[WIDTH*m_win +: WIDTH];
        m_gnt = 4'(1 << m_win);
        m_ptr = (m_win + 1) % NREQ;
        m_age = 0;
      end
    end else if (m_age == 0) begin
      m_gnt   = '0;
      m_valid = 1'b1;
      m_data  = gate_ref(m_op, m_a, m_b);
      m_err   = (m_op == 3'd7);
      m_age   = 1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
      m_age   = -1;
    end
  endtask

  initial begin
    vecs[0] = '{0, 3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{2, 3'd0, 8'hA5, 8'h0F, 8'h5A, 1'b0};
    vecs[2] = '{2, 3'd1, 8'hA5, 8'h0F, 8'h05, 1'b0};
    vecs[3] = '{2, 3'd2, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    vecs[4] = '{2, 3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b0};
    vecs[5] = '{2, 3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0};
    vecs[6] = '{2, 3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b0};
    vecs[7] = '{2, 3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0};
    vecs[8] = '{2, 3'd7, 8'hA5, 8'h0F, 8'h00, 1'b1};

    do_reset();
    for (int i = 0; i < 9; i++) serve(vecs[i]);

    // All four requesting continuously: grants 0,1,2,3,0 three cycles apart.
    do_reset();
    req       = 4'b1111;
    op        = {4{3'd2}};
    a         = 32'h1122_3344;
    b         = 32'h0F0F_0F0F;
    rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      check("rr_gnt", 32'(gnt), (c % 3 == 0) ? (32'(1) << ((c / 3) % 4)) : 0);
      if (c % 3 == 1) check("rr_id", 32'(rsp_id), 32'((c / 3) % 4));
    end

    // Requesters 0 and 3 alternate.
    do_reset();
    req       = 4'b1001;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c % 3 == 0) check("fair_gnt", 32'(gnt), ((c / 3) % 2 == 0) ? 32'h1 : 32'h8);
    end

    // After a grant to 1, requesters 1 and 2 pending: 2 goes next.
    do_reset();
    req       = 4'b0010;
    rsp_ready = 1'b1;
    tick();
    check("fair_g1", 32'(gnt), 32'h2);
    req = 4'b0110;
    tick();
    tick();
    tick();
    check("fair_g2", 32'(gnt), 32'h4);

    // Backpressure in DONE with another requester waiting.
    do_reset();
    req       = 4'b0011;
    op        = {3'd0, 3'd0, 3'd1, 3'd5};
    a         = {8'h00, 8'h00, 8'h77, 8'h3C};
    b         = {8'h00, 8'h00, 8'h0F, 8'hFF};
    rsp_ready = 1'b0;
    tick();
    check("bp_gnt0", 32'(gnt), 32'h1);
    req = 4'b0010;
    tick();
    check("bp_valid", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_data",  32'(rsp_data), 32'hC3);
      check("bp_hold_id",    32'(rsp_id), 0);
      check("bp_hold_busy",  32'(busy), 1);
      check("bp_hold_gnt",   32'(gnt), 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(rsp_valid), 0);
    check("bp_release_gnt",   32'(gnt), 0);
    tick();
    check("bp_next_gnt", 32'(gnt), 32'h2);

    // Reset while in EXEC aborts the transaction and clears the pointer.
    do_reset();
    req       = 4'b0100;
    op        = '0;
    rsp_ready = 1'b1;
    tick();
    check("rx_gnt", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    req   = 4'b1100;
    tick();
    check("rx_gnt_clr",  32'(gnt), 0);
    check("rx_valid",    32'(rsp_valid), 0);
    check("rx_data",     32'(rsp_data), 0);
    check("rx_id",       32'(rsp_id), 0);
    check("rx_err",      32'(rsp_err), 0);
    check("rx_busy",     32'(busy), 0);
    rst_n = 1'b1;
    tick();
    check("rx_first_gnt", 32'(gnt), 32'h4);
    check("rx_no_valid",  32'(rsp_valid), 0);

    // Randomized run against the model.
    do_reset();
    m_ptr = 0; m_age = -1; m_win = 0; m_gnt = '0; m_valid = 1'b0;
    m_err = 1'b0; m_data = '0; m_op = '0; m_a = '0; m_b = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      op        = 12'($urandom);
      a         = $urandom;
      b         = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
      model_step();
      check("rnd_gnt",   32'(gnt), 32'(m_gnt));
      check("rnd_valid", 32'(rsp_valid), 32'(m_valid));
      check("rnd_busy",  32'(busy), (m_age >= 0) ? 32'h1 : 32'h0);
      if (m_valid) begin
        check("rnd_data", 32'(rsp_data), 32'(m_data));
        check("rnd_id",   32'(rsp_id), 32'(m_win));
        check("rnd_err",  32'(rsp_err), 32'(m_err));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_unit_arbiter.md
# gate_unit_arbiter

Round-robin arbiter and sequencer that shares one bitwise logic-gate evaluation unit (NOT/AND/OR/NAND/NOR/XOR/XNOR) between NREQ requesters. It accepts one request at a time, latches its opcode and operands, and evaluates them in the shared gate unit. It then returns the registered result with the winner's ID over a valid/ready response channel. The block sits between the requesting blocks and the gate datapath, so only one gate unit is instantiated.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width; gates apply bitwise
- clk  in  1  rising-edge clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- req  in  NREQ  per-requester request
- op  in  3*NREQ  opcode of requester i at bits [3i+2:3i]
- a  in  WIDTH*NREQ  operand A of requester i at [WIDTH*i+WIDTH-1:WIDTH*i]
- b  in  WIDTH*NREQ  operand B, same packing
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  WIDTH  result
- rsp_id  out  $clog2(NREQ)  index of the served requester
- rsp_err  out  1  illegal opcode flag
- busy  out  1  high whenever the state is not IDLE

## Operation
- Opcodes: 0 NOT(a), 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal. For opcode 7, rsp_data=0 and rsp_err=1. For all other opcodes, rsp_err=0.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: when req≠0 at a clock edge, select the winner. Latch op/a/b of the winner, set gnt to one-hot(winner), and move to EXEC. When req=0, stay in IDLE.
  - EXEC: the gate unit evaluates the latched operands. At the next edge, register rsp_data/rsp_err/rsp_id, set rsp_valid=1, clear gnt, and move to DONE.
  - DONE: hold rsp_valid and the response fields stable until an edge where rsp_ready=1. At that edge, clear rsp_valid and move to IDLE.
- Round-robin arbitration: pointer ptr resets to 0. Search from ptr upward, modulo NREQ, and take the first set req bit. After a grant to i, ptr ← (i+1) mod NREQ. ptr changes only on a grant.
- req is ignored in EXEC and DONE; requests are never queued.
- A requester holds req/op/a/b stable until it sees its gnt. If req is still high after gnt, it counts as a new request.
- Operands are latched at grant, so changing a/b after gnt does not affect the result.
- busy = (state≠IDLE).

## Timing
- Reset: when rst_n=0 at an edge, the block enters IDLE with gnt=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, and ptr=0. This applies in any state.
- Reset mid-transaction aborts the transaction; no response is produced for it.
- Reset is synchronous: outputs change only at a clock edge.
- Edge E0 (IDLE, req≠0): gnt is high in cycle E0→E1 only.
- Edge E1: rsp_valid rises. Latency from the request-sampling edge to rsp_valid is 1 edge (2 edges from request to the first ready-sampling edge).
- If rsp_ready=1 at E2, the handshake completes at E2 and the FSM is in IDLE after E2. A new grant can occur at E3.
- Maximum throughput is one transaction per 3 cycles.
- rsp_ready low holds DONE indefinitely, with all response outputs stable and no grants.
- rsp_ready high outside DONE has no effect.
- gnt is never asserted while rsp_valid=1, and at most one gnt bit is high at a time.

## Test plan
- Reset, then req=4'b0001, op0=1, a0=8'hF0, b0=8'h3C, rsp_ready=1:
  - gnt=0001 for exactly one cycle.
  - Next cycle: rsp_valid=1, rsp_data=8'h30, rsp_id=0, rsp_err=0.
  - rsp_valid drops after one cycle.
- Opcode sweep 0..6 on requester 2 with a=8'hA5, b=8'h0F:
  - Expected rsp_data: 5A, 05, AF, FA, 50, AA, 55 with rsp_id=2.
  - op=7 → rsp_data=00, rsp_err=1.
- All four req held high from reset, rsp_ready=1:
  - Grants in order 0,1,2,3,0, spaced 3 cycles apart.
  - rsp_id follows the same order.
- Fairness: req=4'b1001 continuously:
  - Grants alternate 0,3,0,3.
  - With req=4'b0110 after a grant to 1, the next grant is 2.
- Backpressure: rsp_ready=0 for 5 cycles while DONE, with other reqs pending:
  - rsp_valid, rsp_data, and rsp_id stay stable, busy=1, and no gnt.
  - Raising rsp_ready completes the handshake, and the next grant follows one cycle later.
- rst_n=0 asserted in EXEC:
  - After the edge, all outputs are 0 and no rsp_valid appears.
  - The first grant after reset goes to the lowest-index requester (ptr=0).
